// File: rtl/arb_single_port_mem_if.sv
// Request/response bundle for arb_single_port_mem.
// Per-channel request slices (valid/ready/write/addr/wdata/be) plus shared read response.
interface arb_single_port_mem_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 10,
    parameter int Channels  = 4
);
    logic [Channels-1:0]               req_valid;
    logic [Channels-1:0]               req_ready;
    logic [Channels-1:0]               req_write;
    logic [Channels*AddrWidth-1:0]     req_addr;
    logic [Channels*DataWidth-1:0]     req_wdata;
    logic [Channels*(DataWidth/8)-1:0] req_be;
    logic [Channels-1:0]               rsp_valid;
    logic [DataWidth-1:0]              rsp_data;
    logic                              rsp_err;
    logic                              wr_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_data, rsp_err, wr_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_data, rsp_err, wr_err
    );
endinterface

// File: rtl/arb_single_port_mem.sv
// Round-robin arbitrated single-port RAM with byte-enable writes and pipelined reads.
// Ports: clk, rst_n (async active-low), bus (slave side of arb_single_port_mem_if).
module arb_single_port_mem #(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 10,
    parameter int Depth       = 1024,
    parameter int BottomAddr  = 0,
    parameter int Channels    = 4,
    parameter int ReadLatency = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    arb_single_port_mem_if.slave  bus
);
    localparam int BeW  = DataWidth / 8;
    localparam int PtrW = (Channels > 1) ? $clog2(Channels) : 1;
    localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [PtrW-1:0]      ptr_q, ptr_d;
    logic                 gnt_found;
    logic [PtrW-1:0]      gnt_idx;
    logic [Channels-1:0]  ready;

    logic                 sel_write;
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] sel_wdata;
    logic [BeW-1:0]       sel_be;
    logic [31:0]          addr_off;
    logic                 in_range;
    logic [IdxW-1:0]      idx;
    logic                 wr_en;
    logic [DataWidth-1:0] rd_data;
    logic [Channels-1:0]  rd_v;
    logic                 wr_err_q;

    logic [DataWidth-1:0] mem_q [Depth];

    logic [Channels-1:0]  pv_q [ReadLatency];
    logic [Channels-1:0]  pv_d [ReadLatency];
    logic [DataWidth-1:0] pd_q [ReadLatency];
    logic [DataWidth-1:0] pd_d [ReadLatency];
    logic                 pe_q [ReadLatency];
    logic                 pe_d [ReadLatency];

    // First requester at or after the pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < Channels; k++) begin
            if (!gnt_found && bus.req_valid[(int'(ptr_q) + k) % Channels]) begin
                gnt_found = 1'b1;
                gnt_idx   = PtrW'((int'(ptr_q) + k) % Channels);
            end
        end
    end

    assign ready         = gnt_found ? (Channels'(1) << gnt_idx) : '0;
    assign bus.req_ready = ready;

    assign ptr_d = gnt_found ? PtrW'((int'(gnt_idx) + 1) % Channels) : ptr_q;

    assign sel_write = bus.req_write[gnt_idx];
    assign sel_addr  = bus.req_addr[gnt_idx*AddrWidth +: AddrWidth];
    assign sel_wdata = bus.req_wdata[gnt_idx*DataWidth +: DataWidth];
    assign sel_be    = bus.req_be[gnt_idx*BeW +: BeW];

    // Unsigned wrap makes addresses below BottomAddr land far above Depth.
    assign addr_off = 32'(sel_addr) - 32'(BottomAddr);
    assign in_range = addr_off < 32'(Depth);
    assign idx      = addr_off[IdxW-1:0];

    assign wr_en   = gnt_found & sel_write & in_range;
    assign rd_data = in_range ? mem_q[idx] : '0;
    assign rd_v    = (gnt_found & ~sel_write) ? ready : '0;

    // RAM array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BeW; b++) begin
                if (sel_be[b]) begin
                    mem_q[idx][8*b +: 8] <= sel_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        pv_d[0] = rd_v;
        pd_d[0] = rd_data;
        pe_d[0] = (|rd_v) & ~in_range;
        for (int s = 1; s < ReadLatency; s++) begin
            pv_d[s] = pv_q[s-1];
            pd_d[s] = pd_q[s-1];
            pe_d[s] = pe_q[s-1];
        end
    end

    // Data registers only load with a valid beat so rsp_data holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            wr_err_q <= 1'b0;
            for (int s = 0; s < ReadLatency; s++) begin
                pv_q[s] <= '0;
                pd_q[s] <= '0;
                pe_q[s] <= 1'b0;
            end
        end else begin
            ptr_q    <= ptr_d;
            wr_err_q <= gnt_found & sel_write & ~in_range;
            for (int s = 0; s < ReadLatency; s++) begin
                pv_q[s] <= pv_d[s];
                pe_q[s] <= pe_d[s];
                if (|pv_d[s]) begin
                    pd_q[s] <= pd_d[s];
                end
            end
        end
    end

    assign bus.rsp_valid = pv_q[ReadLatency-1];
    assign bus.rsp_data  = pd_q[ReadLatency-1];
    assign bus.rsp_err   = pe_q[ReadLatency-1];
    assign bus.wr_err    = wr_err_q;
endmodule

// File: tb/tb_arb_single_port_mem.sv
// Testbench for arb_single_port_mem: two instances (read latency 1 and 3) driven identically.
// Randomized requesters are checked every cycle against a behavioural arbiter/RAM model.
module tb_arb_single_port_mem;
    localparam int DW  = 32;
    localparam int AW  = 11;
    localparam int DEP = 1024;
    localparam int BOT = 0;
    localparam int CH  = 4;
    localparam int BW  = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arb_single_port_mem_if #(.DataWidth(DW), .AddrWidth(AW), .Channels(CH)) if1 ();
    arb_single_port_mem_if #(.DataWidth(DW), .AddrWidth(AW), .Channels(CH)) if3 ();

    arb_single_port_mem #(
        .DataWidth(DW), .AddrWidth(AW), .Depth(DEP), .BottomAddr(BOT),
        .Channels(CH), .ReadLatency(1)
    ) u_l1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    arb_single_port_mem #(
        .DataWidth(DW), .AddrWidth(AW), .Depth(DEP), .BottomAddr(BOT),
        .Channels(CH), .ReadLatency(3)
    ) u_l3 (
        .clk(clk), .rst_n(rst_n), .bus(if3)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Requester state: each channel holds one request until granted.
    bit          pv [CH];
    bit          pw [CH];
    int unsigned pa [CH];
    logic [31:0] pd [CH];
    logic [3:0]  pb [CH];

    // Reference model.
    logic [31:0] mem [DEP];
    int          ptr;
    int          cyc;
    int          lat [2] = '{1, 3};
    logic [3:0]  ev [2][8];
    logic [31:0] ed [2][8];
    bit          ee [2][8];
    bit          ew [8];
    logic [31:0] lastd [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic post(input int c, input bit w, input int unsigned a,
                        input logic [31:0] d, input logic [3:0] b);
        pv[c] = 1'b1; pw[c] = w; pa[c] = a; pd[c] = d; pb[c] = b;
    endtask

    task automatic drive();
        logic [CH-1:0]    v, w;
        logic [CH*AW-1:0] a;
        logic [CH*DW-1:0] d;
        logic [CH*BW-1:0] b;
        for (int c = 0; c < CH; c++) begin
            v[c] = pv[c];
            w[c] = pw[c];
            a[c*AW +: AW] = AW'(pa[c]);
            d[c*DW +: DW] = pd[c];
            b[c*BW +: BW] = pb[c];
        end
        if1.req_valid = v; if1.req_write = w; if1.req_addr = a;
        if1.req_wdata = d; if1.req_be = b;
        if3.req_valid = v; if3.req_write = w; if3.req_addr = a;
        if3.req_wdata = d; if3.req_be = b;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            lastd[i] = '0;
            for (int s = 0; s < 8; s++) begin
                ev[i][s] = '0; ed[i][s] = '0; ee[i][s] = 1'b0;
            end
        end
        for (int s = 0; s < 8; s++) ew[s] = 1'b0;
        for (int c = 0; c < CH; c++) pv[c] = 1'b0;
        ptr = 0;
    endtask

    task automatic step();
        int g, slot, c, ns;
        logic [3:0] er;
        logic [31:0] rd;
        bit inr;
        drive();
        @(negedge clk);
        g = -1;
        for (int k = 0; k < CH; k++) begin
            c = (ptr + k) % CH;
            if (g < 0 && pv[c]) g = c;
        end
        er = (g >= 0) ? 4'(1 << g) : 4'h0;
        chk("ready_l1", 64'(if1.req_ready), 64'(er));
        chk("ready_l3", 64'(if3.req_ready), 64'(er));
        slot = cyc % 8;
        for (int i = 0; i < 2; i++) begin
            if (ev[i][slot] != 0) lastd[i] = ed[i][slot];
        end
        chk("rsp_valid_l1", 64'(if1.rsp_valid), 64'(ev[0][slot]));
        chk("rsp_valid_l3", 64'(if3.rsp_valid), 64'(ev[1][slot]));
        chk("rsp_err_l1", 64'(if1.rsp_err), 64'(ee[0][slot]));
        chk("rsp_err_l3", 64'(if3.rsp_err), 64'(ee[1][slot]));
        chk("rsp_data_l1", 64'(if1.rsp_data), 64'(lastd[0]));
        chk("rsp_data_l3", 64'(if3.rsp_data), 64'(lastd[1]));
        chk("wr_err_l1", 64'(if1.wr_err), 64'(ew[slot]));
        chk("wr_err_l3", 64'(if3.wr_err), 64'(ew[slot]));
        for (int i = 0; i < 2; i++) begin
            ev[i][slot] = '0; ee[i][slot] = 1'b0;
        end
        ew[slot] = 1'b0;
        if (g >= 0) begin
            inr = (pa[g] >= BOT) && (pa[g] < BOT + DEP);
            if (pw[g]) begin
                if (inr) begin
                    for (int b = 0; b < 4; b++)
                        if (pb[g][b]) mem[pa[g]-BOT][8*b +: 8] = pd[g][8*b +: 8];
                end else begin
                    ew[(cyc + 1) % 8] = 1'b1;
                end
            end else begin
                rd = inr ? mem[pa[g]-BOT] : 32'h0;
                for (int i = 0; i < 2; i++) begin
                    ns = (cyc + lat[i]) % 8;
                    ev[i][ns] = 4'(1 << g);
                    ed[i][ns] = rd;
                    ee[i][ns] = !inr;
                end
            end
            pv[g] = 1'b0;
            ptr = (g + 1) % CH;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_idle(input int budget);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            busy = 1'b0;
            for (int c = 0; c < CH; c++) busy |= pv[c];
            if (busy) begin
                step();
                n++;
            end
        end
        chk("idle_timeout", 64'(busy), 64'(0));
        repeat (4) step();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid_l1"}, 64'(if1.rsp_valid), 64'(0));
        chk({tag, "_valid_l3"}, 64'(if3.rsp_valid), 64'(0));
        chk({tag, "_data_l1"}, 64'(if1.rsp_data), 64'(0));
        chk({tag, "_data_l3"}, 64'(if3.rsp_data), 64'(0));
        chk({tag, "_err_l1"}, 64'(if1.rsp_err), 64'(0));
        chk({tag, "_err_l3"}, 64'(if3.rsp_err), 64'(0));
        chk({tag, "_wrerr_l1"}, 64'(if1.wr_err), 64'(0));
        chk({tag, "_wrerr_l3"}, 64'(if3.wr_err), 64'(0));
    endtask

    initial begin
        cyc = 0;
        clear_model();
        drive();
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All four channels reading continuously: grants rotate 0,1,2,3.
        repeat (16) begin
            for (int c = 0; c < CH; c++)
                if (!pv[c]) post(c, 1'b0, 32'(c * 3), 32'h0, 4'h0);
            step();
        end
        run_idle(16);

        // Preload so every later read has defined data.
        for (int a = 0; a < DEP; a++) begin
            post(a % CH, 1'b1, 32'(a), $urandom, 4'hF);
            step();
        end
        run_idle(8);

        post(0, 1'b1, 5, 32'hDEADBEEF, 4'hF);
        run_idle(8);
        post(1, 1'b0, 5, 32'h0, 4'h0);
        run_idle(8);
        chk("t1_data_l1", 64'(if1.rsp_data), 64'h00000000DEADBEEF);
        chk("t1_data_l3", 64'(if3.rsp_data), 64'h00000000DEADBEEF);

        post(2, 1'b1, 7, 32'h11223344, 4'hF);
        run_idle(8);
        post(3, 1'b1, 7, 32'hAABBCCDD, 4'b0101);
        run_idle(8);
        post(0, 1'b0, 7, 32'h0, 4'h0);
        run_idle(8);
        chk("be_data_l1", 64'(if1.rsp_data), 64'h0000000011BB33DD);
        chk("be_data_l3", 64'(if3.rsp_data), 64'h0000000011BB33DD);

        post(1, 1'b0, DEP + BOT, 32'h0, 4'h0);
        run_idle(8);
        post(2, 1'b1, DEP + BOT, 32'hCAFEF00D, 4'hF);
        run_idle(8);
        post(3, 1'b0, 0, 32'h0, 4'h0);
        run_idle(8);

        // Back-to-back reads of 0,1,2 on consecutive cycles.
        post(0, 1'b0, 0, 32'h0, 4'h0);
        post(1, 1'b0, 1, 32'h0, 4'h0);
        post(2, 1'b0, 2, 32'h0, 4'h0);
        run_idle(8);

        // Reset with reads in flight.
        post(1, 1'b0, 10, 32'h0, 4'h0);
        post(2, 1'b0, 11, 32'h0, 4'h0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        clear_model();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) post(c, 1'b0, 32'(20 + c), 32'h0, 4'h0);
        run_idle(16);

        // Randomized mix, including out-of-range addresses and sparse byte enables.
        repeat (2000) begin
            for (int c = 0; c < CH; c++) begin
                if (!pv[c] && $urandom_range(0, 2) == 0)
                    post(c, 1'($urandom_range(0, 1)), $urandom_range(0, DEP + 15),
                         $urandom, 4'($urandom_range(0, 15)));
            end
            step();
        end
        run_idle(16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
